// File: rtl/ifetch_controller.sv
// Instruction-fetch sequencer: arbitrates program loading against pipeline fetch, owns the PC and
// the IF/ID register, and handles stall, redirect and halt.
module ifetch_controller #(
    parameter logic [7:0]  START_PC  = 8'd0,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter logic        WRAP_EN   = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_ld_valid,
    output logic        o_ld_ready,
    input  logic [7:0]  i_ld_addr,
    input  logic [31:0] i_ld_data,
    output logic        o_imem_we,
    output logic [7:0]  o_imem_waddr,
    output logic [31:0] o_imem_wdata,
    output logic [7:0]  o_imem_addr,
    input  logic [31:0] i_imem_data,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [7:0]  i_redirect_pc,
    output logic [31:0] o_instr_out,
    output logic [7:0]  o_pc_out,
    output logic        o_instr_valid,
    output logic [8:0]  o_ld_count,
    output logic        o_halted,
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StLoad = 2'b01,
        StRun  = 2'b10,
        StHalt = 2'b11
    } state_t;

    state_t      r_state;
    logic [7:0]  r_pc;
    logic [31:0] r_instr;
    logic [7:0]  r_pc_out;
    logic        r_instr_valid;
    logic        r_halted;
    logic        r_imem_we;
    logic [7:0]  r_imem_waddr;
    logic [31:0] r_imem_wdata;
    logic [8:0]  r_ld_count;

    logic w_beat;
    logic w_enter_run;

    assign o_ld_ready  = (r_state != StRun);
    assign w_beat      = i_ld_valid & o_ld_ready;
    // A beat always wins over start in the same cycle.
    assign w_enter_run = (r_state != StRun) & ~w_beat & i_start;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_pc          <= 8'd0;
            r_instr       <= 32'd0;
            r_pc_out      <= 8'd0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_imem_we     <= 1'b0;
            r_imem_waddr  <= 8'd0;
            r_imem_wdata  <= 32'd0;
            r_ld_count    <= 9'd0;
        end else begin
            r_imem_we <= w_beat;
            if (w_beat) begin
                r_imem_waddr  <= i_ld_addr;
                r_imem_wdata  <= i_ld_data;
                r_state       <= StLoad;
                r_halted      <= 1'b0;
                r_instr_valid <= 1'b0;
                if (r_ld_count != 9'd256) begin
                    r_ld_count <= r_ld_count + 9'd1;
                end
            end else if (w_enter_run) begin
                r_state       <= StRun;
                r_pc          <= START_PC;
                r_instr_valid <= 1'b0;
                r_ld_count    <= 9'd0;
                r_halted      <= 1'b0;
            end else if (r_state == StRun) begin
                if (i_redirect_valid) begin
                    r_pc          <= i_redirect_pc;
                    r_instr_valid <= 1'b0;
                end else if (i_stall) begin
                    r_pc <= r_pc;
                end else if (i_imem_data == HALT_WORD) begin
                    r_instr_valid <= 1'b0;
                    r_state       <= StHalt;
                    r_halted      <= 1'b1;
                end else begin
                    r_instr       <= i_imem_data;
                    r_pc_out      <= r_pc;
                    r_instr_valid <= 1'b1;
                    // Without wrap, address 255 is the last word issued before halting.
                    if (r_pc == 8'd255 && !WRAP_EN) begin
                        r_state  <= StHalt;
                        r_halted <= 1'b1;
                    end else begin
                        r_pc <= r_pc + 8'd1;
                    end
                end
            end else begin
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign o_imem_we     = r_imem_we;
    assign o_imem_waddr  = r_imem_waddr;
    assign o_imem_wdata  = r_imem_wdata;
    assign o_imem_addr   = r_pc;
    assign o_instr_out   = r_instr;
    assign o_pc_out      = r_pc_out;
    assign o_instr_valid = r_instr_valid;
    assign o_ld_count    = r_ld_count;
    assign o_halted      = r_halted;
    assign o_state       = r_state;

endmodule

// File: tb/tb_ifetch_controller.sv
// Directed bench: three controllers share stimulus; dut0 (defaults) owns the write port of a
// behavioural memory that all three read, dut1/dut2 start at 254 without/with wrap.
module tb_ifetch_controller;

    logic        clk = 1'b0;
    logic        reset, start, ld_valid, stall, redirect_valid;
    logic [7:0]  ld_addr, redirect_pc;
    logic [31:0] ld_data;
    logic [31:0] mem [256];

    logic        rdy0, rdy1, rdy2, we0, we1, we2, v0, v1, v2, h0, h1, h2;
    logic [7:0]  wa0, wa1, wa2, a0, a1, a2, p0, p1, p2;
    logic [31:0] wd0, wd1, wd2, i0, i1, i2;
    logic [8:0]  c0, c1, c2;
    logic [1:0]  s0, s1, s2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (we0) mem[wa0] <= wd0;

    ifetch_controller dut0 (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_ld_valid(ld_valid), .o_ld_ready(rdy0),
        .i_ld_addr(ld_addr), .i_ld_data(ld_data), .o_imem_we(we0), .o_imem_waddr(wa0),
        .o_imem_wdata(wd0), .o_imem_addr(a0), .i_imem_data(mem[a0]), .i_stall(stall),
        .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc), .o_instr_out(i0),
        .o_pc_out(p0), .o_instr_valid(v0), .o_ld_count(c0), .o_halted(h0), .o_state(s0)
    );

    ifetch_controller #(.START_PC(8'd254), .WRAP_EN(1'b0)) dut1 (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_ld_valid(ld_valid), .o_ld_ready(rdy1),
        .i_ld_addr(ld_addr), .i_ld_data(ld_data), .o_imem_we(we1), .o_imem_waddr(wa1),
        .o_imem_wdata(wd1), .o_imem_addr(a1), .i_imem_data(mem[a1]), .i_stall(stall),
        .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc), .o_instr_out(i1),
        .o_pc_out(p1), .o_instr_valid(v1), .o_ld_count(c1), .o_halted(h1), .o_state(s1)
    );

    ifetch_controller #(.START_PC(8'd254), .WRAP_EN(1'b1)) dut2 (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_ld_valid(ld_valid), .o_ld_ready(rdy2),
        .i_ld_addr(ld_addr), .i_ld_data(ld_data), .o_imem_we(we2), .o_imem_waddr(wa2),
        .o_imem_wdata(wd2), .o_imem_addr(a2), .i_imem_data(mem[a2]), .i_stall(stall),
        .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc), .o_instr_out(i2),
        .o_pc_out(p2), .o_instr_valid(v2), .o_ld_count(c2), .o_halted(h2), .o_state(s2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] addr, input logic [31:0] data);
        ld_valid = 1'b1; ld_addr = addr; ld_data = data;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); reset = 1'b0;
        n_cmp++; if (s0 !== 2'b00) begin n_fail++; $display("FAIL reset_state got %b want 00", s0); end
        n_cmp++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", rdy0); end
        n_cmp++; if ({we0, v0, h0} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {we0, v0, h0}); end
        n_cmp++; if ({c0, a0, p0, i0} !== 57'd0) begin n_fail++; $display("FAIL reset_regs got %h want 0", {c0, a0, p0, i0}); end
    endtask

    task automatic test_load();
        logic [31:0] words [3];
        words[0] = 32'h0C01_0018; words[1] = 32'h3000_0003; words[2] = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            ld_valid = 1'b1; ld_addr = 8'(k); ld_data = words[k];
            tick();
            n_cmp++;
            if ({we0, wa0, wd0} !== {1'b1, 8'(k), words[k]}) begin
                n_fail++; $display("FAIL load_beat%0d got we=%b a=%h d=%h want 1/%h/%h", k, we0, wa0, wd0, k, words[k]);
            end
            n_cmp++; if (s0 !== 2'b01) begin n_fail++; $display("FAIL load_state%0d got %b want 01", k, s0); end
        end
        ld_valid = 1'b0;
        tick();
        n_cmp++; if (we0 !== 1'b0) begin n_fail++; $display("FAIL load_we_drop got %b want 0", we0); end
        n_cmp++; if (c0 !== 9'd3) begin n_fail++; $display("FAIL load_count got %0d want 3", c0); end
    endtask

    task automatic test_run_halt();
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++; if ({s0, rdy0, v0, a0, c0} !== {2'b10, 1'b0, 1'b0, 8'd0, 9'd0}) begin
            n_fail++; $display("FAIL run_entry got s=%b r=%b v=%b a=%0d c=%0d want 10/0/0/0/0", s0, rdy0, v0, a0, c0);
        end
        tick();
        n_cmp++; if ({v0, i0, p0, a0} !== {1'b1, 32'h0C01_0018, 8'd0, 8'd1}) begin
            n_fail++; $display("FAIL run_fetch0 got v=%b i=%h p=%0d a=%0d want 1/0c010018/0/1", v0, i0, p0, a0);
        end
        tick();
        n_cmp++; if ({v0, i0, p0, a0} !== {1'b1, 32'h3000_0003, 8'd1, 8'd2}) begin
            n_fail++; $display("FAIL run_fetch1 got v=%b i=%h p=%0d a=%0d want 1/30000003/1/2", v0, i0, p0, a0);
        end
        tick();
        n_cmp++; if ({v0, h0, s0, a0, i0} !== {1'b0, 1'b1, 2'b11, 8'd2, 32'h3000_0003}) begin
            n_fail++; $display("FAIL run_halt got v=%b h=%b s=%b a=%0d i=%h want 0/1/11/2/30000003", v0, h0, s0, a0, i0);
        end
    endtask

    task automatic test_reload();
        logic [7:0] addrs [12];
        addrs = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd254, 8'd255};
        for (int k = 0; k < 12; k++) beat(addrs[k], 32'h2000_0000 | 32'(addrs[k]));
        tick();
        n_cmp++; if ({s0, h0, c0} !== {2'b01, 1'b0, 9'd12}) begin
            n_fail++; $display("FAIL reload got s=%b h=%b c=%0d want 01/0/12", s0, h0, c0);
        end
    endtask

    task automatic test_stall();
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if ({v0, i0, p0, a0} !== {1'b1, 32'h2000_0003, 8'd3, 8'd4}) begin
                n_fail++; $display("FAIL stall_hold%0d got v=%b i=%h p=%0d a=%0d want 1/20000003/3/4", k, v0, i0, p0, a0);
            end
        end
        stall = 1'b0;
        tick();
        n_cmp++; if ({v0, i0, p0, a0} !== {1'b1, 32'h2000_0004, 8'd4, 8'd5}) begin
            n_fail++; $display("FAIL stall_resume got v=%b i=%h p=%0d a=%0d want 1/20000004/4/5", v0, i0, p0, a0);
        end
    endtask

    task automatic test_redirect();
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'd10;
        tick();
        stall = 1'b0; redirect_valid = 1'b0;
        n_cmp++; if ({v0, a0} !== {1'b0, 8'd10}) begin
            n_fail++; $display("FAIL redirect_bubble got v=%b a=%0d want 0/10", v0, a0);
        end
        tick();
        n_cmp++; if ({v0, i0, p0} !== {1'b1, 32'h2000_000A, 8'd10}) begin
            n_fail++; $display("FAIL redirect_target got v=%b i=%h p=%0d want 1/2000000a/10", v0, i0, p0);
        end
    endtask

    task automatic test_wrap();
        reset = 1'b1; tick(); reset = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++; if ({a1, a2} !== {8'd254, 8'd254}) begin
            n_fail++; $display("FAIL wrap_entry got a1=%0d a2=%0d want 254/254", a1, a2);
        end
        tick();
        n_cmp++; if ({v1, i1, p1, v2, i2, p2} !== {1'b1, 32'h2000_00FE, 8'd254, 1'b1, 32'h2000_00FE, 8'd254}) begin
            n_fail++; $display("FAIL wrap_254 got %b %h %0d / %b %h %0d want 1 200000fe 254 x2", v1, i1, p1, v2, i2, p2);
        end
        tick();
        n_cmp++; if ({v1, i1, p1, s1} !== {1'b1, 32'h2000_00FF, 8'd255, 2'b11}) begin
            n_fail++; $display("FAIL nowrap_255 got v=%b i=%h p=%0d s=%b want 1/200000ff/255/11", v1, i1, p1, s1);
        end
        n_cmp++; if ({v2, i2, p2, s2} !== {1'b1, 32'h2000_00FF, 8'd255, 2'b10}) begin
            n_fail++; $display("FAIL wrap_255 got v=%b i=%h p=%0d s=%b want 1/200000ff/255/10", v2, i2, p2, s2);
        end
        tick();
        n_cmp++; if ({v1, h1} !== 2'b01) begin n_fail++; $display("FAIL nowrap_halt got v=%b h=%b want 0/1", v1, h1); end
        n_cmp++; if ({v2, i2, p2} !== {1'b1, 32'h2000_0000, 8'd0}) begin
            n_fail++; $display("FAIL wrap_0 got v=%b i=%h p=%0d want 1/20000000/0", v2, i2, p2);
        end
        tick();
        n_cmp++; if ({v2, i2, p2} !== {1'b1, 32'h2000_0001, 8'd1}) begin
            n_fail++; $display("FAIL wrap_1 got v=%b i=%h p=%0d want 1/20000001/1", v2, i2, p2);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; tick(); reset = 1'b0;
        beat(8'd6, 32'h2000_0006);
        reset = 1'b1; ld_valid = 1'b1; ld_addr = 8'd7; ld_data = 32'hDEAD_BEEF;
        tick();
        reset = 1'b0; ld_valid = 1'b0;
        n_cmp++; if ({we0, wa0, wd0, c0, s0, rdy0} !== {1'b0, 8'd0, 32'd0, 9'd0, 2'b00, 1'b1}) begin
            n_fail++; $display("FAIL rst_midload got we=%b a=%h d=%h c=%0d s=%b r=%b want 0/0/0/0/00/1", we0, wa0, wd0, c0, s0, rdy0);
        end
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        n_cmp++; if ({v0, p0} !== {1'b1, 8'd1}) begin n_fail++; $display("FAIL rst_prerun got v=%b p=%0d want 1/1", v0, p0); end
        reset = 1'b1; tick(); reset = 1'b0;
        n_cmp++; if ({i0, p0, v0, h0, s0, a0, we0} !== {32'd0, 8'd0, 1'b0, 1'b0, 2'b00, 8'd0, 1'b0}) begin
            n_fail++; $display("FAIL rst_midrun got i=%h p=%0d v=%b h=%b s=%b a=%0d we=%b want all 0", i0, p0, v0, h0, s0, a0, we0);
        end
        ld_valid = 1'b1; start = 1'b1; ld_addr = 8'd6; ld_data = 32'h2000_0006;
        tick();
        ld_valid = 1'b0; start = 1'b0;
        n_cmp++; if ({s0, we0, c0} !== {2'b01, 1'b1, 9'd1}) begin
            n_fail++; $display("FAIL beat_vs_start got s=%b we=%b c=%0d want 01/1/1", s0, we0, c0);
        end
        tick();
        n_cmp++; if ({s0, we0} !== {2'b01, 1'b0}) begin
            n_fail++; $display("FAIL load_idle got s=%b we=%b want 01/0", s0, we0);
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 32'd0;
        reset = 1'b1; start = 1'b0; ld_valid = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        ld_addr = 8'd0; ld_data = 32'd0; redirect_pc = 8'd0;
        tick();
        test_reset();
        test_load();
        test_run_halt();
        test_reload();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
